control_pila: RTL

//   Sequencer/arbiter for the hardware return-address stack (pila). Two requesters

---
 rtl/pila_pkg.sv | 25 ++
 rtl/arbitro_pila.sv | 50 +++++
 rtl/control_pila.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pila_pkg.sv
// pila_pkg
//   Shared definitions for the return-address stack controller: sequencer state
//   encoding, operation codes, requester identifiers and default sizing.
//   Optional build macro used by the slice: PILA_RR_EN (round-robin arbitration).
package pila_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int DEPTH_DEF  = 16;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        EJEC   = 2'd1,
        RESP   = 2'd2
    } estado_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_INT = 1'b1
    } req_id_t;

endpackage

// File: rtl/arbitro_pila.sv
// arbitro_pila
//   Two-way arbiter between the CPU and the interrupt unit. Produces a one-hot
//   selection from the current requests; the controller only acts on it in REPOSO.
//   Build macro PILA_RR_EN:
//     undefined - fixed priority, the interrupt unit wins a tie.
//     defined   - round-robin, a tie goes to whoever was not granted last; the
//                 last-grant pointer starts at CPU so the interrupt unit wins the
//                 first tie. The pointer moves only when avanza is high.
// Ports
//   clk, reset  clock / synchronous active-high reset (round-robin build only)
//   avanza      grant is being taken this cycle (REPOSO -> EJEC)
//   req_cpu     CPU request
//   req_int     interrupt-unit request
//   sel_cpu     CPU selected
//   sel_int     interrupt unit selected
module arbitro_pila
    import pila_pkg::*;
(
`ifdef PILA_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic avanza,
`endif
    input  logic req_cpu,
    input  logic req_int,
    output logic sel_cpu,
    output logic sel_int
);

`ifdef PILA_RR_EN
    req_id_t ultimo;
    logic    prefiere_int;

    assign prefiere_int = (ultimo == REQ_CPU);
    assign sel_int      = req_int & (~req_cpu | prefiere_int);
    assign sel_cpu      = req_cpu & ~sel_int;

    always_ff @(posedge clk) begin
        if (reset) begin
            ultimo <= REQ_CPU;
        end else if (avanza) begin
            ultimo <= sel_int ? REQ_INT : REQ_CPU;
        end
    end
`else
    assign sel_int = req_int;
    assign sel_cpu = req_cpu & ~req_int;
`endif

endmodule

// File: rtl/control_pila.sv
// control_pila
//   Sequencer/arbiter in front of the hardware return-address stack (pila). Grants
//   one requester at a time, drives the pila strobes, tracks occupancy so that
//   pushes on full and pops on empty are refused, captures popped data and keeps a
//   sticky error flag. The pila's own SP and memory are not touched here.
//   Build macro PILA_RR_EN selects round-robin instead of fixed (int-first) priority.
// Ports
//   clk, reset           clock / synchronous active-high reset (shared with pila)
//   req_cpu/op_cpu/dato_cpu  CPU request, 1=push 0=pop, push data
//   req_int/op_int/dato_int  interrupt-unit request, 1=push 0=pop, push data
//   gnt_cpu, gnt_int     owner of the operation in flight (EJEC and RESP)
//   listo, err_op        one-cycle completion pulse, refused-operation flag
//   dato_sal             last legally popped value
//   lleno, vacio         occupancy at DEPTH / at zero
//   error                sticky: some operation refused since reset
//   weSP, push, pop      strobes to pila
//   entrada              push data to pila
//   salida               pila top-of-stack (combinational)
//
// state  | meaning
// REPOSO | idle, no grant; arbitrate and launch the next operation
// EJEC   | grant and strobes to pila; counter and dato_sal update at end of cycle
// RESP   | grant held, listo pulse with err_op
module control_pila
    import pila_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_cpu,
    input  logic              op_cpu,
    input  logic [DATA_W-1:0] dato_cpu,
    input  logic              req_int,
    input  logic              op_int,
    input  logic [DATA_W-1:0] dato_int,
    output logic              gnt_cpu,
    output logic              gnt_int,
    output logic              listo,
    output logic              err_op,
    output logic [DATA_W-1:0] dato_sal,
    output logic              lleno,
    output logic              vacio,
    output logic              error,
    output logic              weSP,
    output logic              push,
    output logic              pop,
    output logic [DATA_W-1:0] entrada,
    input  logic [DATA_W-1:0] salida
);

    estado_t           estado;
    logic [CNT_W-1:0]  cuenta;
    logic              err_pend;
    logic              sel_cpu, sel_int, avanza;
    logic              op_sel;
    logic [DATA_W-1:0] dato_sel;

    assign lleno    = (cuenta == CNT_W'(DEPTH));
    assign vacio    = (cuenta == '0);
    assign avanza   = (estado == REPOSO) & (sel_cpu | sel_int);
    assign op_sel   = sel_int ? op_int   : op_cpu;
    assign dato_sel = sel_int ? dato_int : dato_cpu;

    arbitro_pila u_arbitro (
`ifdef PILA_RR_EN
        .clk     (clk),
        .reset   (reset),
        .avanza  (avanza),
`endif
        .req_cpu (req_cpu),
        .req_int (req_int),
        .sel_cpu (sel_cpu),
        .sel_int (sel_int)
    );

    // Legality is decided on entry to EJEC from the settled count, so the pila
    // strobes can come straight out of registers during EJEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= REPOSO;
            cuenta   <= '0;
            err_pend <= 1'b0;
            gnt_cpu  <= 1'b0;
            gnt_int  <= 1'b0;
            listo    <= 1'b0;
            err_op   <= 1'b0;
            dato_sal <= '0;
            error    <= 1'b0;
            weSP     <= 1'b0;
            push     <= 1'b0;
            pop      <= 1'b0;
            entrada  <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (avanza) begin
                        estado  <= EJEC;
                        gnt_cpu <= sel_cpu;
                        gnt_int <= sel_int;
                        if (op_sel == OP_PUSH) begin
                            if (!lleno) begin
                                push    <= 1'b1;
                                weSP    <= 1'b1;
                                entrada <= dato_sel;
                            end else begin
                                err_pend <= 1'b1;
                            end
                        end else begin
                            if (!vacio) begin
                                pop  <= 1'b1;
                                weSP <= 1'b1;
                            end else begin
                                err_pend <= 1'b1;
                            end
                        end
                    end
                end
                EJEC: begin
                    estado   <= RESP;
                    push     <= 1'b0;
                    pop      <= 1'b0;
                    weSP     <= 1'b0;
                    entrada  <= '0;
                    listo    <= 1'b1;
                    err_op   <= err_pend;
                    err_pend <= 1'b0;
                    if (err_pend) error <= 1'b1;
                    if (push) cuenta <= cuenta + CNT_W'(1);
                    if (pop) begin
                        cuenta   <= cuenta - CNT_W'(1);
                        dato_sal <= salida;
                    end
                end
                RESP: begin
                    estado  <= REPOSO;
                    gnt_cpu <= 1'b0;
                    gnt_int <= 1'b0;
                    listo   <= 1'b0;
                    err_op  <= 1'b0;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule
